// File: rtl/nibble_serial_subtractor.sv
`timescale 1ns/1ps
// nibble_serial_subtractor
//
// Computes D = A - B - BIN one 4-bit nibble per clock, LSB nibble first.
// Each nibble step uses a carry-select stage: both possible 4-bit results
// (incoming borrow 0 and incoming borrow 1) are formed, and the registered
// working borrow picks one of them.
//
// Handshake: START is a request that is taken only while the block is idle
// (BUSY=0). The edge that takes it captures A, B and BIN and raises BUSY.
// BUSY stays high until the edge that finishes the last nibble. That edge
// drops BUSY, raises DONE for exactly one cycle and updates D/BOUT/ZERO.
// START is ignored while BUSY=1. A START held during the DONE cycle is taken
// at once, so operations can run back to back with no gap.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   START  in   request a subtraction (idle only)
//   A      in   minuend, WIDTH bits
//   B      in   subtrahend, WIDTH bits
//   BIN    in   borrow-in
//   BUSY   out  operation in progress
//   DONE   out  one-cycle completion pulse
//   D      out  difference, held until the next completion
//   BOUT   out  borrow-out, held until the next completion
//   ZERO   out  D == 0, held until the next completion
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             ZERO
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [IW-1:0]    idx;
    logic             borrow_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum_b0;
    logic [4:0]       sum_b1;
    logic [4:0]       sel;
    logic             borrow_next;
    logic [WIDTH-1:0] work_next;

    // Nibble select, carry-select subtract and write-back of nibble idx.
    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        work_next = work_q;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
        // Subtraction as A + ~B + 1; a borrow-in removes the +1.
        sum_b0      = {1'b0, a_nib} + {1'b0, ~b_nib} + 5'd1;
        sum_b1      = {1'b0, a_nib} + {1'b0, ~b_nib};
        sel         = borrow_q ? sum_b1 : sum_b0;
        // No carry out of the nibble means the nibble needed a borrow.
        borrow_next = ~sel[4];
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                work_next[4*k +: 4] = sel[3:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            idx      <= '0;
            borrow_q <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            D        <= '0;
            BOUT     <= 1'b0;
            ZERO     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= BIN;
                        work_q   <= '0;
                        idx      <= '0;
                        BUSY     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    work_q   <= work_next;
                    borrow_q <= borrow_next;
                    if (idx == LAST) begin
                        // Only the finished word ever reaches D.
                        D     <= work_next;
                        BOUT  <= borrow_next;
                        ZERO  <= (work_next == '0);
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
`timescale 1ns/1ps
// Testbench for nibble_serial_subtractor (WIDTH=16): directed vectors with
// hand-computed results. The driver pushes each expected {D,BOUT,ZERO} into
// a queue when it issues START; a monitor pops and compares on every DONE.
module tb_nibble_serial_subtractor;

    localparam int W = 16;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] D;
    logic         BOUT;
    logic         ZERO;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT),
        .ZERO  (ZERO)
    );

    // Clock and watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state.
    logic [W+1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: act=D 0x%0h req=no DONE at %0t", D, $time);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("result{D,BOUT,ZERO}", {14'd0, D, BOUT, ZERO}, {14'd0, e});
            end
        end
    end

    // Driver: call just after a falling edge; START is taken on the next rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input logic expect_done, input logic [W-1:0] ed,
                            input logic eb, input logic ez);
        A     = a;
        B     = b;
        BIN   = bin;
        START = 1'b1;
        if (expect_done) exp_q.push_back({ed, eb, ez});
    endtask

    // Waits (bounded) for DONE, checking that D holds its old value meanwhile
    // and that DONE arrives after exactly exp_lat falling edges.
    task automatic wait_done(input int exp_lat, input logic [W-1:0] ed);
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            check("d_hold", {16'd0, D}, {16'd0, last_d});
            @(negedge CLK);
            n++;
        end
        if (DONE !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: act=no DONE req=DONE within 20 cycles");
        end else begin
            check("latency", n, exp_lat);
            check("busy_at_done", {31'd0, BUSY}, 32'd0);
            last_d = ed;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic ez);
        @(negedge CLK);
        start_op(a, b, bin, 1'b1, ed, eb, ez);
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", {31'd0, BUSY}, 32'd1);
        wait_done(4, ed);
        @(negedge CLK);
        check("done_one_cycle", {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        A     = '0;
        B     = '0;
        BIN   = 1'b0;

        // Reset values before any clock edge.
        #3;
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_d",    {16'd0, D},    32'd0);
        check("rst_bout", {31'd0, BOUT}, 32'd0);
        check("rst_zero", {31'd0, ZERO}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("zero_after_release", {31'd0, ZERO}, 32'd0);

        // Arithmetic vectors.
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
        run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // START again at edge 2 with new operands, inputs disturbed mid-run.
        @(negedge CLK);
        start_op(16'h0050, 16'h0010, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        start_op(16'hAAAA, 16'h1111, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        wait_done(2, 16'h0040);
        repeat (8) @(negedge CLK);
        check("no_extra_done_busy", {31'd0, BUSY}, 32'd0);

        // Back-to-back: START held during the DONE cycle.
        @(negedge CLK);
        start_op(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        wait_done(4, 16'h00FF);
        start_op(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        check("b2b_busy", {31'd0, BUSY}, 32'd1);
        wait_done(4, 16'h0002);
        @(negedge CLK);
        check("b2b_done_one_cycle", {31'd0, DONE}, 32'd0);

        // Reset between edges 1 and 2 of an operation: aborts, no DONE.
        @(negedge CLK);
        start_op(16'h4444, 16'h1111, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_d",    {16'd0, D},    32'd0);
        check("abort_bout", {31'd0, BOUT}, 32'd0);
        check("abort_zero", {31'd0, ZERO}, 32'd0);
        last_d = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        check("abort_no_done_busy", {31'd0, BUSY}, 32'd0);
        check("abort_zero_hold", {31'd0, ZERO}, 32'd0);
        run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
